// File: rtl/alu_pkg.sv
// Opcodes, FSM states and op-class decode for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUBC = 3'b001;
  localparam logic [2:0] OP_MOVA = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_ADD1 = 3'b110;
  localparam logic [2:0] OP_MOVB = 3'b111;

  localparam logic [2:0] LOP_AND = 3'b000;
  localparam logic [2:0] LOP_OR  = 3'b001;
  localparam logic [2:0] LOP_XOR = 3'b010;
  localparam logic [2:0] LOP_NOT = 3'b011;
  localparam logic [2:0] LOP_SHL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CL_ADD,
    CL_SUB,
    CL_MOVE,
    CL_LOGIC,
    CL_SHIFT
  } op_class_t;

  typedef enum logic [1:0] {
    X_B,
    X_NB,
    X_ZERO,
    X_ONE
  } x_sel_t;

  typedef enum logic [1:0] {
    C0_CIN,
    C0_NCIN,
    C0_ZERO,
    C0_ONE
  } c0_sel_t;

  typedef struct packed {
    op_class_t cls;
    x_sel_t    xsel;
    c0_sel_t   c0;
  } op_dec_t;

  function automatic op_dec_t op_decode(
    input logic [2:0] opsel,
    input logic       mode
  );
    op_dec_t d;
    d.cls  = CL_LOGIC;
    d.xsel = X_B;
    d.c0   = C0_ZERO;
    if (mode) begin
      if (opsel == LOP_SHL) d.cls = CL_SHIFT;
    end else begin
      case (opsel)
        OP_ADD:  begin d.cls = CL_ADD; d.c0 = C0_CIN; end
        OP_SUBC: begin
          d.cls  = CL_SUB;
          d.xsel = X_NB;
          d.c0   = C0_NCIN;
        end
        OP_SUB:  begin
          d.cls  = CL_SUB;
          d.xsel = X_NB;
          d.c0   = C0_ONE;
        end
        OP_INC:  begin
          d.cls  = CL_ADD;
          d.xsel = X_ZERO;
          d.c0   = C0_ONE;
        end
        OP_DEC:  begin d.cls = CL_SUB; d.xsel = X_ONE; end
        OP_ADD1: begin d.cls = CL_ADD; d.c0 = C0_ONE; end
        default: begin d.cls = CL_MOVE; d.xsel = X_ZERO; end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice; carry and previous-bit state live outside.
module serial_alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       x,
  input  logic       c,
  input  logic       prev_a,
  input  logic [2:0] opsel,
  input  logic       mode,
  output logic       out,
  output logic       c_next
);

  always_comb begin
    c_next = (a & x) | (c & (a ^ x));
    out    = 1'b0;
    if (!mode) begin
      out = a ^ x ^ c;
    end else begin
      unique case (1'b1)
        (opsel == LOP_AND): out = a & x;
        (opsel == LOP_OR):  out = a | x;
        (opsel == LOP_XOR): out = a ^ x;
        (opsel == LOP_NOT): out = ~a;
        (opsel == LOP_SHL): out = prev_a;
        default:            out = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_serial_nbit.sv
// WIDTH-bit ALU evaluated one bit per clock, LSB first,
// with start/busy/done handshake and registered flags.
module alu_serial_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [2:0]       opsel,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_nx;
  logic [WIDTH-2:0] acc;
  logic [2:0]       op_q;
  logic             mode_q;
  op_class_t        cls_q;
  x_sel_t           xsel_q;
  op_dec_t          dec_in;
  logic             c_q, prev_q, c0;
  logic             x_bit, out_bit, c_next;
  logic             cout_nx, accept, last;

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && (state != ST_RUN);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign dec_in = op_decode(opsel, mode);

  always_comb begin
    c0 = 1'b0;
    unique case (dec_in.c0)
      C0_CIN:  c0 = cin;
      C0_NCIN: c0 = ~cin;
      C0_ONE:  c0 = 1'b1;
      default: c0 = 1'b0;
    endcase
  end

  always_comb begin
    x_bit = 1'b0;
    unique case (xsel_q)
      X_B:     x_bit = b_sh[0];
      X_NB:    x_bit = ~b_sh[0];
      X_ONE:   x_bit = 1'b1;
      default: x_bit = 1'b0;
    endcase
  end

  serial_alu_slice u_slice (
    .a      (a_sh[0]),
    .x      (x_bit),
    .c      (c_q),
    .prev_a (prev_q),
    .opsel  (op_q),
    .mode   (mode_q),
    .out    (out_bit),
    .c_next (c_next)
  );

  assign res_nx = {out_bit, acc};

  // Sub class reports borrow, the inverse of the final carry.
  always_comb begin
    cout_nx = 1'b0;
    unique case (cls_q)
      CL_ADD:   cout_nx = c_next;
      CL_SUB:   cout_nx = ~c_next;
      CL_SHIFT: cout_nx = a_sh[0];
      default:  cout_nx = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      op_q   <= '0;
      mode_q <= 1'b0;
      cls_q  <= CL_ADD;
      xsel_q <= X_B;
      c_q    <= 1'b0;
      prev_q <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sh   <= A;
      b_sh   <= B;
      op_q   <= opsel;
      mode_q <= mode;
      cls_q  <= dec_in.cls;
      xsel_q <= dec_in.xsel;
      c_q    <= c0;
      prev_q <= 1'b0;
    end else if (busy) begin
      cnt    <= cnt + CNT_W'(1);
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      acc    <= res_nx[WIDTH-1:1];
      c_q    <= c_next;
      prev_q <= a_sh[0];
      if (last) begin
        result <= res_nx;
        cout   <= cout_nx;
        zero   <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Bench for alu_serial_nbit: directed, random and handshake scenarios
// against an arithmetic reference model.
module tb_alu_serial_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [2:0]   opsel = '0;
  logic         mode = 1'b0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_serial_nbit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a),
    .B      (b),
    .cin    (cin),
    .opsel  (opsel),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c,
    input logic [2:0]   op,
    input logic         m
  );
    int ai, bi, ci, s;
    logic [W-1:0] r;
    logic co;
    ai = int'(x);
    bi = int'(y);
    ci = int'(c);
    s  = 0;
    r  = '0;
    co = 1'b0;
    if (!m) begin
      case (op)
        3'd0, 3'd4, 3'd6: begin
          if (op == 3'd0) s = ai + bi + ci;
          else if (op == 3'd4) s = ai + 1;
          else s = ai + bi + 1;
          r  = s[W-1:0];
          co = (s >= (1 << W));
        end
        3'd1, 3'd3, 3'd5: begin
          if (op == 3'd1) s = ai - bi - ci;
          else if (op == 3'd3) s = ai - bi;
          else s = ai - 1;
          r  = s[W-1:0];
          co = (s < 0);
        end
        default: r = x;
      endcase
    end else begin
      case (op)
        3'd0: r = x & y;
        3'd1: r = x | y;
        3'd2: r = x ^ y;
        3'd3: r = ~x;
        3'd4: begin r = x << 1; co = x[W-1]; end
        default: r = '0;
      endcase
    end
    return {co, r};
  endfunction

  task automatic run_op(
    input  logic [W-1:0] ia,
    input  logic [W-1:0] ib,
    input  logic         ic,
    input  logic [2:0]   iop,
    input  logic         im,
    output int           lat,
    output int           bcnt,
    output logic         seen
  );
    @(negedge clk);
    a = ia; b = ib; cin = ic; opsel = iop; mode = im;
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    bcnt = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    seen = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (result !== '0) begin
      fails++; $display("FAIL reset_result got %h want 00", result);
    end
    checks++;
    if (cout !== 1'b0) begin
      fails++; $display("FAIL reset_cout got %b want 0", cout);
    end
    checks++;
    if (zero !== 1'b0) begin
      fails++; $display("FAIL reset_zero got %b want 0", zero);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [2:0]   op;
    logic         m;
    logic [W-1:0] r;
    logic         co;
    logic         z;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    int lat, bcnt;
    logic seen;
    v[0]  = '{8'hF0, 8'h20, 1'b1, 3'b000, 1'b0, 8'h11, 1'b1, 1'b0};
    v[1]  = '{8'h05, 8'h07, 1'b0, 3'b011, 1'b0, 8'hFE, 1'b1, 1'b0};
    v[2]  = '{8'h00, 8'h33, 1'b0, 3'b101, 1'b0, 8'hFF, 1'b1, 1'b0};
    v[3]  = '{8'hFF, 8'h00, 1'b0, 3'b100, 1'b0, 8'h00, 1'b1, 1'b1};
    v[4]  = '{8'h81, 8'h00, 1'b0, 3'b100, 1'b1, 8'h02, 1'b1, 1'b0};
    v[5]  = '{8'h5A, 8'h5A, 1'b0, 3'b010, 1'b1, 8'h00, 1'b0, 1'b1};
    v[6]  = '{8'hC3, 8'h3C, 1'b1, 3'b110, 1'b1, 8'h00, 1'b0, 1'b1};
    v[7]  = '{8'h10, 8'h01, 1'b1, 3'b001, 1'b0, 8'h0E, 1'b0, 1'b0};
    v[8]  = '{8'h3C, 8'hAA, 1'b1, 3'b010, 1'b0, 8'h3C, 1'b0, 1'b0};
    v[9]  = '{8'h0F, 8'hF0, 1'b0, 3'b000, 1'b1, 8'h00, 1'b0, 1'b1};
    v[10] = '{8'h0F, 8'hF0, 1'b0, 3'b001, 1'b1, 8'hFF, 1'b0, 1'b0};
    v[11] = '{8'hA5, 8'h00, 1'b0, 3'b011, 1'b1, 8'h5A, 1'b0, 1'b0};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].c, v[i].op, v[i].m, lat, bcnt, seen);
      checks++;
      if (!seen || lat != 9) begin
        fails++;
        $display("FAIL dir%0d_latency got %0d want 9", i, lat);
      end
      checks++;
      if (bcnt != 8) begin
        fails++;
        $display("FAIL dir%0d_busy got %0d want 8", i, bcnt);
      end
      checks++;
      if (result !== v[i].r) begin
        fails++;
        $display("FAIL dir%0d_result got %h want %h",
                 i, result, v[i].r);
      end
      checks++;
      if (cout !== v[i].co) begin
        fails++;
        $display("FAIL dir%0d_cout got %b want %b", i, cout, v[i].co);
      end
      checks++;
      if (zero !== v[i].z) begin
        fails++;
        $display("FAIL dir%0d_zero got %b want %b", i, zero, v[i].z);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic rc, rm;
    logic [2:0] rop;
    logic [W:0] exp;
    int lat, bcnt;
    logic seen;
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      rop = 3'($urandom_range(0, 7));
      rm  = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rc, rop, rm);
      run_op(ra, rb, rc, rop, rm, lat, bcnt, seen);
      checks++;
      if (!seen || lat != 9) begin
        fails++;
        $display("FAIL rnd%0d_latency got %0d want 9", i, lat);
      end
      checks++;
      if (result !== exp[W-1:0] || cout !== exp[W]) begin
        fails++;
        $display("FAIL rnd%0d m%b op%0d a=%h b=%h c=%b got %b/%h want %b/%h",
                 i, rm, rop, ra, rb, rc, cout, result,
                 exp[W], exp[W-1:0]);
      end
      checks++;
      if (zero !== (exp[W-1:0] == '0)) begin
        fails++;
        $display("FAIL rnd%0d_zero got %b want %b",
                 i, zero, (exp[W-1:0] == '0));
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W:0] exp;
    logic [W-1:0] r_at;
    logic c_at;
    int ndone, first;
    exp = model(8'h12, 8'h34, 1'b0, 3'b000, 1'b0);
    ndone = 0;
    first = -1;
    r_at = '0;
    c_at = 1'b0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; opsel = 3'b000; mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 0) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; opsel = 3'b011;
      end
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i; r_at = result; c_at = cout;
        end
      end
      if (i < 14) @(posedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin
      fails++; $display("FAIL ign_done_count got %0d want 1", ndone);
    end
    checks++;
    if (first != 8) begin
      fails++; $display("FAIL ign_done_cycle got %0d want 8", first);
    end
    checks++;
    if (r_at !== exp[W-1:0] || c_at !== exp[W]) begin
      fails++;
      $display("FAIL ign_result got %b/%h want %b/%h",
               c_at, r_at, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [W:0] e1, e2;
    logic [W-1:0] r1, rmid, r2;
    int d1, d2;
    logic bmid, dmid;
    e1 = model(8'h77, 8'h11, 1'b0, 3'b011, 1'b0);
    e2 = model(8'h81, 8'h00, 1'b0, 3'b100, 1'b1);
    d1 = -1; d2 = -1;
    r1 = '0; rmid = '0; r2 = '0;
    bmid = 1'b0; dmid = 1'b1;
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; opsel = 3'b011; mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a = 8'h81; b = 8'h00; opsel = 3'b100; mode = 1'b1;
      end
      if (i == 9) begin
        start = 1'b0; bmid = busy; dmid = done;
      end
      if (i == 13) rmid = result;
      if (done && d1 < 0) begin
        d1 = i; r1 = result;
      end else if (done && d2 < 0) begin
        d2 = i; r2 = result;
      end
      if (i < 21) @(posedge clk);
    end
    checks++;
    if (d1 != 8 || r1 !== e1[W-1:0]) begin
      fails++;
      $display("FAIL b2b_first got cyc %0d res %h want cyc 8 res %h",
               d1, r1, e1[W-1:0]);
    end
    checks++;
    if (bmid !== 1'b1 || dmid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept got busy %b done %b want 1 0",
               bmid, dmid);
    end
    checks++;
    if (rmid !== e1[W-1:0]) begin
      fails++;
      $display("FAIL b2b_hold got %h want %h", rmid, e1[W-1:0]);
    end
    checks++;
    if (d2 != 17) begin
      fails++; $display("FAIL b2b_second_cycle got %0d want 17", d2);
    end
    checks++;
    if (r2 !== e2[W-1:0] || cout !== e2[W]) begin
      fails++;
      $display("FAIL b2b_second got %b/%h want %b/%h",
               cout, r2, e2[W], e2[W-1:0]);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'h9C; b = 8'h21; cin = 1'b0; opsel = 3'b000; mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, zero} !== 4'b0 || result !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs got b%b d%b c%b z%b r%h want all 0",
               busy, done, cout, zero, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL rstmid_no_done got %0d active cycles want 0", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
